// File: rtl/lsu_split_bus_if.sv
// Core-side request/response and memory-side bus signals of the load/store unit.
// Latency: none, pure signal bundle.
// Backpressure: req_ready/resp_ack toward the core, Mem_Req_Ack/Read_data_Valid toward memory.
interface lsu_split_bus_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = DATA_W / 8;

  // core side
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ack;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;

  // memory side
  logic [ADDR_W-1:0] Address;
  logic              MemWrite;
  logic              MemRead;
  logic [DATA_W-1:0] Write_data;
  logic [NB-1:0]     Write_strb;
  logic              Mem_Req_Ack;
  logic [DATA_W-1:0] Read_data;
  logic              Read_data_Valid;
  logic              Read_data_Ack;

  // the load/store unit itself
  modport slave (
    input  req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata, resp_ack,
    input  Mem_Req_Ack, Read_data, Read_data_Valid,
    output req_ready, resp_valid, resp_data, resp_err,
    output Address, MemWrite, MemRead, Write_data, Write_strb, Read_data_Ack
  );

  // the environment: core plus memory
  modport master (
    output req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata, resp_ack,
    output Mem_Req_Ack, Read_data, Read_data_Valid,
    input  req_ready, resp_valid, resp_data, resp_err,
    input  Address, MemWrite, MemRead, Write_data, Write_strb, Read_data_Ack
  );
endinterface

// File: rtl/lsu_split_bus.sv
// Load/store unit: aligns, strobes and splits core accesses onto a word-wide memory bus.
// Latency: aligned store 2, aligned load 3, split load 5 cycles to response with zero-wait memory.
// Backpressure: one transaction in flight; req_ready low until the core acks the response.
module lsu_split_bus #(
  parameter int DATA_W           = 32,
  parameter int ADDR_W           = 32,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  lsu_split_bus_if.slave bus,
  output logic [31:0]    cnt_split
);
  localparam int NB = DATA_W / 8;
  localparam int OB = $clog2(NB);

  typedef enum logic [5:0] {
    IDLE = 6'b000001,
    REQ0 = 6'b000010,
    RDW0 = 6'b000100,
    REQ1 = 6'b001000,
    RDW1 = 6'b010000,
    RESP = 6'b100000
  } state_t;

  state_t            state;
  logic              lat_wen;
  logic [1:0]        lat_size;
  logic              lat_uns;
  logic [OB-1:0]     lat_off;
  logic              lat_cross;
  logic [DATA_W-1:0] lat_wdata;
  logic [NB-1:0]     lat_strb_hi;
  logic [DATA_W-1:0] beat0;
  logic              used_split;

  logic [OB-1:0]     req_off;
  int                req_bytes;
  logic              req_cross;
  logic              req_illegal;
  logic [2*NB-1:0]   req_mask;

  // Shift the two captured beats into place, keep the accessed bytes and extend them.
  function automatic logic [DATA_W-1:0] load_result(
    input logic [DATA_W-1:0] b0,
    input logic [DATA_W-1:0] b1,
    input logic [OB-1:0]     off,
    input logic [1:0]        size,
    input logic              uns
  );
    logic [DATA_W-1:0] raw;
    int                sh;
    raw = b0 >> (8 * int'(off));
    if (off != '0) raw = raw | (b1 << (DATA_W - 8 * int'(off)));
    // left-justify the accessed bytes, then shift back down with the wanted fill
    sh  = DATA_W - (8 << size);
    raw = raw << sh;
    if (uns) raw = raw >> sh;
    else     raw = $signed(raw) >>> sh;
    return raw;
  endfunction

  // Decode the incoming request: byte offset, access size, lane mask across two words.
  always_comb begin
    req_off     = bus.req_addr[OB-1:0];
    req_bytes   = 1 << bus.req_size;
    req_cross   = (int'(req_off) + req_bytes) > NB;
    req_illegal = (bus.req_size == 2'd3) && (DATA_W == 32);
    req_mask    = ~({(2*NB){1'b1}} << req_bytes);
    req_mask    = req_mask << req_off;
  end

  // Transaction FSM; every bus and response output is a register written here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      bus.req_ready     <= 1'b1;
      bus.resp_valid    <= 1'b0;
      bus.resp_err      <= 1'b0;
      bus.resp_data     <= '0;
      bus.Address       <= '0;
      bus.MemWrite      <= 1'b0;
      bus.MemRead       <= 1'b0;
      bus.Write_data    <= '0;
      bus.Write_strb    <= '0;
      bus.Read_data_Ack <= 1'b0;
      cnt_split         <= '0;
      lat_wen           <= 1'b0;
      lat_size          <= '0;
      lat_uns           <= 1'b0;
      lat_off           <= '0;
      lat_cross         <= 1'b0;
      lat_wdata         <= '0;
      lat_strb_hi       <= '0;
      beat0             <= '0;
      used_split        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            lat_wen       <= bus.req_wen;
            lat_size      <= bus.req_size;
            lat_uns       <= bus.req_unsigned;
            lat_off       <= req_off;
            lat_cross     <= req_cross;
            lat_wdata     <= bus.req_wdata;
            lat_strb_hi   <= req_mask[2*NB-1:NB];
            used_split    <= 1'b0;
            if (req_illegal || (req_cross && !SPLIT_MISALIGNED)) begin
              // rejected without touching the bus
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_data  <= '0;
            end else begin
              state       <= REQ0;
              bus.Address <= {bus.req_addr[ADDR_W-1:OB], {OB{1'b0}}};
              if (bus.req_wen) begin
                bus.MemWrite   <= 1'b1;
                bus.Write_data <= bus.req_wdata << (8 * int'(req_off));
                bus.Write_strb <= req_mask[NB-1:0];
              end else begin
                bus.MemRead    <= 1'b1;
                bus.Write_strb <= '0;
              end
            end
          end
        end

        REQ0: begin
          if (bus.Mem_Req_Ack) begin
            if (!lat_wen) begin
              bus.MemRead       <= 1'b0;
              bus.Read_data_Ack <= 1'b1;
              state             <= RDW0;
            end else if (lat_cross) begin
              // second store beat goes straight out on the next word
              state          <= REQ1;
              used_split     <= 1'b1;
              bus.Address    <= bus.Address + ADDR_W'(NB);
              bus.Write_data <= lat_wdata >> (DATA_W - 8 * int'(lat_off));
              bus.Write_strb <= lat_strb_hi;
            end else begin
              bus.MemWrite   <= 1'b0;
              bus.Write_strb <= '0;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b0;
              bus.resp_data  <= '0;
              state          <= RESP;
            end
          end
        end

        RDW0: begin
          if (bus.Read_data_Valid) begin
            bus.Read_data_Ack <= 1'b0;
            if (lat_cross) begin
              beat0       <= bus.Read_data;
              used_split  <= 1'b1;
              bus.MemRead <= 1'b1;
              bus.Address <= bus.Address + ADDR_W'(NB);
              state       <= REQ1;
            end else begin
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b0;
              bus.resp_data  <= load_result(bus.Read_data, '0, lat_off, lat_size, lat_uns);
              state          <= RESP;
            end
          end
        end

        REQ1: begin
          if (bus.Mem_Req_Ack) begin
            bus.MemWrite   <= 1'b0;
            bus.MemRead    <= 1'b0;
            bus.Write_strb <= '0;
            if (!lat_wen) begin
              bus.Read_data_Ack <= 1'b1;
              state             <= RDW1;
            end else begin
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b0;
              bus.resp_data  <= '0;
              state          <= RESP;
            end
          end
        end

        RDW1: begin
          if (bus.Read_data_Valid) begin
            bus.Read_data_Ack <= 1'b0;
            bus.resp_valid    <= 1'b1;
            bus.resp_err      <= 1'b0;
            bus.resp_data     <= load_result(beat0, bus.Read_data, lat_off, lat_size, lat_uns);
            state             <= RESP;
          end
        end

        RESP: begin
          if (bus.resp_ack) begin
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.req_ready  <= 1'b1;
            if (used_split) cnt_split <= cnt_split + 32'd1;
            used_split     <= 1'b0;
            state          <= IDLE;
          end
        end

        default: begin
          state             <= IDLE;
          bus.req_ready     <= 1'b1;
          bus.resp_valid    <= 1'b0;
          bus.MemWrite      <= 1'b0;
          bus.MemRead       <= 1'b0;
          bus.Read_data_Ack <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_split_bus.sv
// Bench for lsu_split_bus: directed cases plus random loads/stores against a byte-level model.
// Latency: every bus step is checked on the exact cycle it must occur.
// Backpressure: random memory ack, read-valid and response-ack delays.
module tb_lsu_split_bus;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cnt0;
  logic [31:0] cnt1;

  lsu_split_bus_if #(.DATA_W(32), .ADDR_W(32)) bus0 ();
  lsu_split_bus_if #(.DATA_W(32), .ADDR_W(32)) bus1 ();

  lsu_split_bus #(.DATA_W(32), .ADDR_W(32), .SPLIT_MISALIGNED(1'b1)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .cnt_split(cnt0)
  );
  lsu_split_bus #(.DATA_W(32), .ADDR_W(32), .SPLIT_MISALIGNED(1'b0)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .cnt_split(cnt1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: memory seen as bytes; a 64-bit window spans the two words an access can touch.
  task automatic ref_model(
    input  logic        wen, input logic [1:0] size, input logic uns,
    input  logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rd0, input logic [31:0] rd1,
    output logic err, output int nbeats,
    output logic [31:0] a0, output logic [31:0] a1,
    output logic [31:0] wd0, output logic [31:0] wd1,
    output logic [3:0] st0, output logic [3:0] st1,
    output logic [31:0] rdata
  );
    int          nbytes;
    int          off;
    logic [63:0] window;
    logic [63:0] keep;
    logic [7:0]  lanes;
    nbytes = 1 << size;
    off    = int'(addr % 4);
    err    = (size == 2'd3);
    nbeats = (off + nbytes > 4) ? 2 : 1;
    a0     = addr - addr % 4;
    a1     = a0 + 32'd4;
    window = {32'd0, wdata} << (8 * off);
    wd0    = window[31:0];
    wd1    = window[63:32];
    lanes  = 8'h00;
    for (int i = 0; i < nbytes && i < 4; i++) lanes[off + i] = 1'b1;
    st0    = wen ? lanes[3:0] : 4'h0;
    st1    = wen ? lanes[7:4] : 4'h0;
    window = {rd1, rd0} >> (8 * off);
    keep   = (64'd1 << (8 * nbytes)) - 64'd1;
    window = window & keep;
    if (!uns && window[8 * nbytes - 1]) window = window | ~keep;
    rdata  = (wen || err) ? 32'd0 : window[31:0];
  endtask

  task automatic do_txn(
    input  logic wen, input logic [1:0] size, input logic uns,
    input  logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rd0, input logic [31:0] rd1,
    input  int ack_dly, input int rd_dly, input int resp_dly,
    output logic [31:0] got
  );
    logic        err;
    int          nbeats;
    logic [31:0] a[2];
    logic [31:0] wd[2];
    logic [3:0]  st[2];
    logic [31:0] rd[2];
    logic [31:0] exp_rd;
    ref_model(wen, size, uns, addr, wdata, rd0, rd1, err, nbeats,
              a[0], a[1], wd[0], wd[1], st[0], st[1], exp_rd);
    rd[0] = rd0;
    rd[1] = rd1;
    @(negedge clk);
    check_val("req_ready_idle", bus0.req_ready, 1);
    bus0.req_valid    = 1'b1;
    bus0.req_wen      = wen;
    bus0.req_size     = size;
    bus0.req_unsigned = uns;
    bus0.req_addr     = addr;
    bus0.req_wdata    = wdata;
    @(negedge clk);
    bus0.req_valid = 1'b0;
    if (!err) begin
      for (int k = 0; k < nbeats; k++) begin
        for (int w = 0; w <= ack_dly; w++) begin
          check_val($sformatf("mem_write_b%0d", k), bus0.MemWrite, wen);
          check_val($sformatf("mem_read_b%0d", k), bus0.MemRead, !wen);
          check_val($sformatf("address_b%0d", k), bus0.Address, a[k]);
          check_val($sformatf("strb_b%0d", k), bus0.Write_strb, st[k]);
          if (wen) check_val($sformatf("wdata_b%0d", k), bus0.Write_data, wd[k]);
          if (w < ack_dly) begin
            // stray read data outside a read-wait state must be ignored
            bus0.Read_data_Valid = 1'b1;
            bus0.Read_data       = $urandom;
          end else begin
            bus0.Read_data_Valid = 1'b0;
            bus0.Mem_Req_Ack     = 1'b1;
          end
          @(negedge clk);
        end
        bus0.Mem_Req_Ack = 1'b0;
        if (!wen) begin
          for (int w = 0; w <= rd_dly; w++) begin
            check_val($sformatf("rd_ack_b%0d", k), bus0.Read_data_Ack, 1);
            check_val($sformatf("bus_quiet_rdw_b%0d", k), {bus0.MemRead, bus0.MemWrite}, 0);
            if (w == rd_dly) begin
              bus0.Read_data       = rd[k];
              bus0.Read_data_Valid = 1'b1;
            end
            @(negedge clk);
          end
          bus0.Read_data_Valid = 1'b0;
        end
      end
    end
    got = bus0.resp_data;
    check_val("resp_valid", bus0.resp_valid, 1);
    check_val("resp_err", bus0.resp_err, err);
    check_val("resp_data", bus0.resp_data, exp_rd);
    check_val("bus_quiet_resp", {bus0.MemRead, bus0.MemWrite, bus0.Read_data_Ack}, 0);
    repeat (resp_dly) @(negedge clk);
    if (resp_dly > 0) check_val("resp_hold", {bus0.resp_valid, bus0.resp_data}, {1'b1, exp_rd});
    bus0.resp_ack = 1'b1;
    @(negedge clk);
    bus0.resp_ack = 1'b0;
    if (!err && nbeats == 2) exp_cnt++;
    check_val("resp_drop", bus0.resp_valid, 0);
    check_val("req_ready_back", bus0.req_ready, 1);
    check_val("cnt_split", cnt0, exp_cnt);
  endtask

  // Crossing or illegal access on the non-splitting unit: immediate error, no bus request.
  task automatic nosplit_err(input logic wen, input logic [1:0] size, input logic [31:0] addr);
    @(negedge clk);
    bus1.req_valid = 1'b1;
    bus1.req_wen   = wen;
    bus1.req_size  = size;
    bus1.req_addr  = addr;
    bus1.req_wdata = 32'h5A5A5A5A;
    @(negedge clk);
    bus1.req_valid = 1'b0;
    check_val("ns_bus_quiet", {bus1.MemRead, bus1.MemWrite}, 0);
    check_val("ns_resp_valid", bus1.resp_valid, 1);
    check_val("ns_resp_err", bus1.resp_err, 1);
    check_val("ns_resp_data", bus1.resp_data, 0);
    bus1.resp_ack = 1'b1;
    @(negedge clk);
    bus1.resp_ack = 1'b0;
    check_val("ns_req_ready", bus1.req_ready, 1);
    check_val("ns_cnt_split", cnt1, 0);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] addr;
    logic [1:0]  size;
    rst = 1'b0;
    bus0.req_valid = 0; bus0.req_wen = 0; bus0.req_size = 0; bus0.req_unsigned = 0;
    bus0.req_addr = 0; bus0.req_wdata = 0; bus0.resp_ack = 0;
    bus0.Mem_Req_Ack = 0; bus0.Read_data = 0; bus0.Read_data_Valid = 0;
    bus1.req_valid = 0; bus1.req_wen = 0; bus1.req_size = 0; bus1.req_unsigned = 0;
    bus1.req_addr = 0; bus1.req_wdata = 0; bus1.resp_ack = 0;
    bus1.Mem_Req_Ack = 0; bus1.Read_data = 0; bus1.Read_data_Valid = 0;
    #12;
    check_val("rst_req_ready", bus0.req_ready, 1);
    check_val("rst_flags", {bus0.MemRead, bus0.MemWrite, bus0.Read_data_Ack, bus0.resp_valid, bus0.resp_err}, 0);
    check_val("rst_address", bus0.Address, 0);
    check_val("rst_wdata", bus0.Write_data, 0);
    check_val("rst_strb", bus0.Write_strb, 0);
    check_val("rst_resp_data", bus0.resp_data, 0);
    check_val("rst_cnt", cnt0, 0);
    @(negedge clk);
    rst = 1'b1;

    // directed cases with hand-computed results
    do_txn(0, 2'd2, 0, 32'h100, 0, 32'hDEADBEEF, 32'h0, 0, 0, 0, got);
    check_val("lw_aligned", got, 32'hDEADBEEF);
    do_txn(0, 2'd0, 0, 32'h103, 0, 32'h80112233, 32'h0, 0, 0, 0, got);
    check_val("lb_sign", got, 32'hFFFFFF80);
    do_txn(0, 2'd0, 1, 32'h103, 0, 32'h80112233, 32'h0, 0, 1, 2, got);
    check_val("lbu_zero", got, 32'h00000080);
    do_txn(1, 2'd1, 0, 32'h102, 32'h0000ABCD, 0, 0, 0, 0, 0, got);
    do_txn(1, 2'd2, 0, 32'h1FE, 32'h11223344, 0, 0, 0, 0, 0, got);
    check_val("sw_split_cnt", cnt0, 1);
    do_txn(1, 2'd2, 0, 32'h1FE, 32'h11223344, 0, 0, 3, 0, 0, got);
    do_txn(0, 2'd2, 0, 32'hFFFFFFFE, 0, 32'hAABBCCDD, 32'h11223344, 0, 0, 0, got);
    check_val("lw_wrap", got, 32'h3344AABB);
    do_txn(0, 2'd1, 0, 32'h3, 0, 32'hAABBCCDD, 32'h11223344, 1, 2, 0, got);
    check_val("lh_split", got, 32'h000044AA);
    do_txn(0, 2'd3, 0, 32'h200, 0, 0, 0, 0, 0, 0, got);

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      size = ($urandom % 10 == 0) ? 2'd3 : 2'($urandom % 3);
      addr = ($urandom % 4 == 0) ? (32'hFFFFFFFC | 32'($urandom % 4)) : $urandom;
      do_txn(1'($urandom), size, 1'($urandom), addr, $urandom, $urandom, $urandom,
             int'($urandom % 3), int'($urandom % 3), int'($urandom % 2), got);
    end

    // non-splitting unit
    nosplit_err(0, 2'd2, 32'h1);
    nosplit_err(1, 2'd1, 32'h3);

    // reset while waiting for read data
    @(negedge clk);
    bus0.req_valid = 1'b1; bus0.req_wen = 1'b0; bus0.req_size = 2'd2; bus0.req_addr = 32'h40;
    @(negedge clk);
    bus0.req_valid = 1'b0;
    bus0.Mem_Req_Ack = 1'b1;
    @(negedge clk);
    bus0.Mem_Req_Ack = 1'b0;
    check_val("pre_rst_rd_ack", bus0.Read_data_Ack, 1);
    rst = 1'b0;
    #1;
    check_val("mid_rst_flags", {bus0.MemRead, bus0.Read_data_Ack, bus0.resp_valid}, 0);
    check_val("mid_rst_cnt", cnt0, 0);
    exp_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    bus0.Read_data = 32'h12345678;
    bus0.Read_data_Valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("post_rst_no_resp", bus0.resp_valid, 0);
      check_val("post_rst_ready", bus0.req_ready, 1);
    end
    bus0.Read_data_Valid = 1'b0;
    do_txn(0, 2'd2, 0, 32'h1FF, 0, 32'h44332211, 32'h88776655, 0, 0, 0, got);
    check_val("post_rst_split", got, 32'h77665544);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/lsu_split_bus.md
Name: lsu_split_bus

Overview:
- Parametrised load/store unit between a multicycle RISC-V core's EX stage and the memory request/response handshake channels.
- Accepts one load or store per transaction and generates aligned bus addresses, byte strobes, shifted write data and sign/zero-extended load results.
- Adds a DATA_W-generic datapath (32/64), doubleword support, and automatic two-beat splitting of accesses that cross a bus word, with an error response when splitting is disabled.

Parameters:
- DATA_W, 32, bus and register width; legal values 32 or 64. NB = DATA_W/8, OB = log2(NB).
- ADDR_W, 32, address width.
- SPLIT_MISALIGNED, 1, 1 = split word-crossing accesses into two beats; 0 = reject them with resp_err.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  unit idle and able to accept a request.
- req_wen  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double (legal only when DATA_W=64).
- req_unsigned  in  1  zero-extend the load result.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, LSB-aligned.
- resp_valid  out  1  result or completion available.
- resp_ack  in  1  core accepts the response.
- resp_data  out  DATA_W  extended load data; 0 for stores.
- resp_err  out  1  illegal size, or crossing access with SPLIT_MISALIGNED=0.
- Address  out  ADDR_W  NB-aligned bus address.
- MemWrite  out  1  write request.
- MemRead  out  1  read request.
- Write_data  out  DATA_W  byte-lane-positioned store data.
- Write_strb  out  NB  byte enables.
- Mem_Req_Ack  in  1  memory accepts the request.
- Read_data  in  DATA_W  read data.
- Read_data_Valid  in  1  read data valid.
- Read_data_Ack  out  1  unit accepts read data.
- cnt_split  out  32  count of completed split transactions; wraps modulo 2^32.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state IDLE and req_ready=1;
  - MemRead, MemWrite, Read_data_Ack, resp_valid and resp_err all 0;
  - Address, Write_data, Write_strb, resp_data and cnt_split all 0.
- Reset mid-transaction abandons the access immediately, with no completion to the core.
- States: IDLE, REQ0, RDW0, REQ1, RDW1, RESP, one-hot.
- IDLE:
  - req_ready=1. A request is latched on req_valid & req_ready.
  - Derived values: S = 1<<req_size, off = addr[OB-1:0], cross = off+S > NB.
  - Next state is RESP with resp_err=1, and no bus traffic, if the size is illegal or (cross and SPLIT_MISALIGNED=0).
  - Otherwise next state is REQ0.
- REQ0:
  - Address = {addr[ADDR_W-1:OB], 0}.
  - Store: MemWrite=1, Write_data = wdata << 8*off, Write_strb = ((1<<S)-1) << off, truncated to NB bits.
  - Load: MemRead=1, Write_strb=0.
  - Signals are held stable until Mem_Req_Ack.
  - On ack: load goes to RDW0; store goes to REQ1 if cross, else RESP.
- RDW0:
  - Read_data_Ack=1.
  - On Read_data_Valid, capture beat 0 and go to REQ1 if cross, else RESP.
- REQ1:
  - Address = beat-0 address + NB, modulo 2^ADDR_W.
  - Write_data = wdata >> 8*(NB-off).
  - Write_strb = upper bits of the (2NB)-bit shifted mask.
  - On ack: load goes to RDW1; store goes to RESP.
- RDW1: same as RDW0, capturing beat 1, then RESP.
- Load assembly:
  - Raw data = (beat0 >> 8*off) | (beat1 << 8*(NB-off)); beat1 is 0 when not crossing.
  - Raw data is truncated to S bytes, then sign-extended (or zero-extended if req_unsigned) to DATA_W.
  - Size = double skips extension.
- RESP:
  - resp_valid=1 with resp_data/resp_err held until resp_ack; then IDLE.
  - cnt_split increments on the RESP exit of any transaction that used REQ1.
- Ack timing:
  - Mem_Req_Ack and Read_data_Valid may arrive the same cycle the request is raised.
  - Read_data_Valid outside RDW states is ignored.
- Latency with zero-wait memory:
  - aligned store: 2 cycles to RESP;
  - aligned load: 3 cycles;
  - split load: 5 cycles.
- Bus request outputs are driven from registered state. They are never asserted together, and never asserted in IDLE or RESP.

Test Plan:
1. DATA_W=32, lw 0x100, Read_data=0xDEADBEEF -> one MemRead at Address 0x100, resp_data 0xDEADBEEF, resp_err 0, cnt_split 0.
2. lb 0x103, Read_data=0x80112233 -> resp_data 0xFFFFFF80; repeated as lbu -> 0x00000080.
3. sh 0x102, wdata 0x0000ABCD -> Address 0x100, Write_data 0xABCD0000, Write_strb 4'b1100, single beat.
4. sw 0x1FE, wdata 0x11223344 -> beat0 Address 0x1FC, data 0x33440000, strb 1100; beat1 Address 0x200, data 0x00001122, strb 0011; cnt_split = 1. Repeat with Mem_Req_Ack delayed 3 cycles -> outputs stable throughout.
5. lw 0xFFFFFFFE, beat0 0xAABBCCDD, beat1 0x11223344 -> beat1 Address 0x00000000 (wrap), resp_data 0x3344AABB. Also lh 0x3, beat0 0xAABBCCDD, beat1 0x11223344 -> resp_data 0x000044AA.
6. SPLIT_MISALIGNED=0, lw 0x1 -> resp_err=1, MemRead never asserted. Then rst=0 during RDW0 of an lw -> MemRead, Read_data_Ack and resp_valid drop immediately, req_ready=1 after release, and no response is issued.
